// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: write port, two read ports,
// issue port and the scoreboard busy outputs.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regwrite;
  logic [ADDR_W-1:0] writereg;
  logic [DATA_W-1:0] writedata;
  logic [ADDR_W-1:0] readreg1;
  logic [ADDR_W-1:0] readreg2;
  logic [DATA_W-1:0] readdata1;
  logic [DATA_W-1:0] readdata2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic              busy1;
  logic              busy2;
  logic              busy_any;

  modport master (
    output regwrite, writereg, writedata, readreg1, readreg2, issue_valid, issue_dst,
    input  readdata1, readdata2, busy1, busy2, busy_any
  );

  modport slave (
    input  regwrite, writereg, writedata, readreg1, readreg2, issue_valid, issue_dst,
    output readdata1, readdata2, busy1, busy2, busy_any
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with optional hardwired zero register, write-to-read bypass
// and a per-register busy scoreboard for decode hazard detection.
module rf_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set,
  input  logic              clr,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (we) q <= wdata;
      // a new producer issued in the same cycle the old one retires keeps the reg busy
      if (set)      busy <= 1'b1;
      else if (clr) busy <= 1'b0;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 1 << ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  rf
);
  localparam int NRP = 2;

  logic [NREGS-1:0][DATA_W-1:0] mem;
  logic [NREGS-1:0]             busy;
  logic                         wr_ok;
  logic                         iss_ok;

  logic [NRP-1:0][ADDR_W-1:0]   rreg;
  logic [NRP-1:0][DATA_W-1:0]   rdata;
  logic [NRP-1:0]               rbusy;

  // Index is usable if it maps to a real register and is not the hardwired zero.
  function automatic logic legal(input logic [ADDR_W-1:0] idx);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, idx} < (ADDR_W+1)'(NREGS));
    is_zero  = (ZERO_REG != 0) && (idx == '0);
    return in_range && !is_zero;
  endfunction

  function automatic logic [DATA_W-1:0] sel_data(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < NREGS; i++)
      if (idx == ADDR_W'(i)) d = mem[i];
    return d;
  endfunction

  function automatic logic sel_busy(input logic [ADDR_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (idx == ADDR_W'(i)) b = busy[i];
    return b;
  endfunction

  assign wr_ok  = rf.regwrite    && legal(rf.writereg);
  assign iss_ok = rf.issue_valid && legal(rf.issue_dst);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic hit_w;
      logic hit_i;
      assign hit_w = wr_ok  && (rf.writereg  == ADDR_W'(gi));
      assign hit_i = iss_ok && (rf.issue_dst == ADDR_W'(gi));
      rf_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .we    (hit_w),
        .wdata (rf.writedata),
        .set   (hit_i),
        .clr   (hit_w),
        .q     (mem[gi]),
        .busy  (busy[gi])
      );
    end
  endgenerate

  assign rreg[0] = rf.readreg1;
  assign rreg[1] = rf.readreg2;

  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rd
      logic byp;
      assign byp = (BYPASS != 0) && wr_ok && (rf.writereg == rreg[gi]);
      always_comb begin
        rdata[gi] = '0;
        rbusy[gi] = 1'b0;
        if (rst && legal(rreg[gi])) begin
          rdata[gi] = byp ? rf.writedata : sel_data(rreg[gi]);
          rbusy[gi] = byp ? 1'b0 : sel_busy(rreg[gi]);
        end
      end
    end
  endgenerate

  assign rf.readdata1 = rdata[0];
  assign rf.readdata2 = rdata[1];
  assign rf.busy1     = rbusy[0];
  assign rf.busy2     = rbusy[1];
  // drain indicator reflects stored state only, bypass does not clear it early
  assign rf.busy_any  = rst && (|busy);
endmodule
